bfp16_addsub_pipe: RTL and testbench
====================================

BFP16_ADDSUB_PIPE -- requirements
Module: bfp16_addsub_pipe

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 32: word width; BF16 operand occupies bits [31:16].
REQ-002 SHALL have parameter SIZE_TAG, default 4: width of the user tag carried alongside each operation.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1: the operand pair is valid.
REQ-006 SHALL have port o_ready, output, 1: the block accepts an operation this cycle.
REQ-007 SHALL have port i_op, input, 1: 0 = a+b, 1 = a-b.
REQ-008 SHALL have ports i_data_a and i_data_b, input, SIZE_DATA: operands.
REQ-009 SHALL have port i_tag, input, SIZE_TAG: user tag.
REQ-010 SHALL have port o_valid, output, 1: result valid.
REQ-011 SHALL have port i_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port o_data, output, SIZE_DATA: result; BF16 in [31:16], [15:0] = 0.
REQ-013 SHALL have port o_tag, output, SIZE_TAG: tag of the result.

Function
REQ-014 SHALL accept an operation when i_valid & o_ready, and present a result when o_valid & i_ready.
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/compare/swap/align; S2 signed mantissa add/sub and leading-one normalise; S3 round and pack. Latency is exactly 3 cycles with no stall.
REQ-016 SHALL advance each stage when the stage is empty or the next stage advances.
REQ-017 SHALL compute o_ready = ~S1.valid | S1 advances, so bubbles collapse. Throughput is 1 operation per cycle with i_ready held high.
REQ-018 SHALL hold o_data, o_tag and o_valid stable while o_valid & ~i_ready.
REQ-019 SHALL neither drop nor duplicate results, and SHALL deliver them in acceptance order.
REQ-020 SHALL, when i_op=1, invert the sign of b before any other processing.
REQ-021 SHALL ignore bits [15:0] of i_data_a and i_data_b.
REQ-022 SHALL treat exponent 0 as signed zero (subnormals flushed).
REQ-023 SHALL align using an 8-bit significand plus guard, round and sticky bits. Alignment shift counts of 10 or more SHALL saturate: the smaller operand contributes only to sticky.
REQ-024 SHALL round to nearest, ties to even. A rounding carry-out SHALL renormalise and increment the exponent.
REQ-025 SHALL return an exact zero difference as +0, except (-0)+(-0) = -0.
REQ-026 SHALL return signed infinity (exponent 255, mantissa 0) when the result exponent is 255 or more.
REQ-027 SHALL return signed zero when the result exponent falls below 1.
REQ-028 SHALL return canonical NaN 0x7FC0_0000 for a NaN operand (exp=255, mant≠0) or for +inf + -inf.
REQ-029 SHALL return the infinity, with its sign, for inf combined with a finite operand.
REQ-030 SHALL derive the result sign from the larger-magnitude operand, after the op-adjusted sign of b.

Reset
REQ-031 SHALL clear all stage valid bits on a cycle where i_rst=1; o_valid=0, o_data=0 and o_tag=0 on the following cycle.
REQ-032 SHALL drive o_ready=0 while i_rst=1.
REQ-033 SHALL discard in-flight operations on reset mid-operation, with no result emitted after reset deasserts.
REQ-034 SHALL leave datapath registers other than the outputs without reset.

Structure
REQ-035 SHALL place the BF16 field widths (sign 1, exponent 8, mantissa 7), exponent bias 127, canonical NaN 0x7FC0 and the per-stage packed struct typedefs in shared package bfp16_pkg.
REQ-036 SHALL instantiate one sub-module, bfp16_round_pack (S3: RNE, overflow/underflow, special-case select, pack), to be reusable by a future multiplier.

Verification
REQ-037 SHALL cover: a=0x3F80_0000, b=0x3F80_0000, op=0 -> o_data=0x4000_0000 exactly 3 cycles after acceptance.
REQ-038 SHALL cover: a=0x3F80_0000, b=0x3F80_0000, op=1 -> 0x0000_0000; a=0x3F80_0000, b=0x3B80_0000 (2^-8, tie), op=0 -> 0x3F80_0000 (tie to even).
REQ-039 SHALL cover: 0x7F7F_0000 + 0x7F7F_0000 -> 0x7F80_0000; 0x7F80_0000 + 0xFF80_0000 -> 0x7FC0_0000; 0xFF80_0000 + 0x4000_0000 -> 0xFF80_0000.
REQ-040 SHALL cover backpressure: 6 back-to-back ops (tags 0-5) with i_ready=0 for cycles 2-7. Required: o_ready drops once 3 are held; all 6 results emerge in tag order with correct values; o_data stable while stalled.
REQ-041 SHALL cover reset mid-operation: i_rst=1 for 1 cycle with 2 ops in flight -> o_valid=0 next cycle, no stale result afterwards, and a fresh op completes with 3-cycle latency.
REQ-042 SHALL cover: 0x0001_0000 (subnormal) + 0x3F80_0000 -> 0x3F80_0000; lower-16-bit garbage on inputs does not affect the result.

Source files
------------

// File: rtl/bfp16_pkg.sv
// Shared BF16 field widths, constants and pipeline stage structs for the
// bfloat16 arithmetic blocks.
package bfp16_pkg;

  localparam int          BF_EXP_W  = 8;
  localparam int          BF_MAN_W  = 7;
  localparam int          BF_SIG_W  = BF_MAN_W + 1;
  localparam int          BF_BIAS   = 127;
  localparam int          BF_EXP_MAX = 2 * BF_BIAS + 1;
  localparam logic [15:0] BF_QNAN   = 16'h7FC0;
  localparam int          EXT_W     = BF_SIG_W + 3;   // significand + guard, round, sticky
  localparam int          ALIGN_SAT = 10;

  // S1 -> S2: operands ordered by magnitude, smaller one aligned
  typedef struct packed {
    logic                nan;
    logic                inf;
    logic                inf_sign;
    logic                sign_x;
    logic                sign_y;
    logic                eff_sub;
    logic [BF_EXP_W-1:0] exp_x;
    logic [EXT_W-1:0]    ext_x;
    logic [EXT_W-1:0]    ext_y;
  } s1_t;

  // S2 -> S3: normalised significand {1.mmmmmmm, G, R, S} and unbounded exponent
  typedef struct packed {
    logic               nan;
    logic               inf;
    logic               zero;
    logic               sign;
    logic signed [9:0]  expo;
    logic [EXT_W-1:0]   sig;
  } s2_t;

  function automatic logic [15:0] bf_pack(input logic s, input logic [BF_EXP_W-1:0] e,
                                          input logic [BF_MAN_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/bfp16_round_pack.sv
// Final stage: round-to-nearest-even, overflow/underflow clamping, special
// values and BF16 packing. Purely combinational.
module bfp16_round_pack
  import bfp16_pkg::*;
(
  input  s2_t         i_s2,
  output logic [15:0] o_bf16
);

  logic                w_up;
  logic [BF_SIG_W:0]   w_rnd;
  logic signed [9:0]   w_exp;
  logic [BF_MAN_W-1:0] w_man;

  always_comb begin
    w_up   = i_s2.sig[2] & (i_s2.sig[1] | i_s2.sig[0] | i_s2.sig[3]);
    w_rnd  = {1'b0, i_s2.sig[EXT_W-1:3]} + {{BF_SIG_W{1'b0}}, w_up};
    // carry out of rounding leaves 1.0000000, one binade up
    w_exp  = i_s2.expo + $signed({9'b0, w_rnd[BF_SIG_W]});
    w_man  = w_rnd[BF_SIG_W] ? w_rnd[BF_MAN_W:1] : w_rnd[BF_MAN_W-1:0];
    o_bf16 = bf_pack(i_s2.sign, w_exp[7:0], w_man);
    if (i_s2.nan)
      o_bf16 = BF_QNAN;
    else if (i_s2.inf || w_exp >= 10'(BF_EXP_MAX))
      o_bf16 = bf_pack(i_s2.sign, 8'(BF_EXP_MAX), '0);
    else if (i_s2.zero || w_exp < 10'sd1)
      o_bf16 = bf_pack(i_s2.sign, '0, '0);
  end

endmodule

// File: rtl/bfp16_addsub_pipe.sv
// Three-stage BF16 add/subtract with valid/ready handshake:
// S1 unpack/compare/swap/align, S2 add/sub + normalise, S3 round/pack.
module bfp16_addsub_pipe
  import bfp16_pkg::*;
#(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_TAG  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_op,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic [SIZE_TAG-1:0]  i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic [SIZE_TAG-1:0]  o_tag
);

  localparam int MSB = SIZE_DATA - 1;

  logic [2:0]          r_vld_pipe;
  logic [2:0]          w_adv;
  s1_t                 w_s1, r_s1;
  s2_t                 w_s2, r_s2;
  logic [SIZE_TAG-1:0] r_tag1, r_tag2;
  logic [15:0]         w_a, w_b, w_res;
  logic                w_unused_lo;

  assign w_adv[2] = ~r_vld_pipe[2] | i_ready;
  assign w_adv[1] = ~r_vld_pipe[1] | w_adv[2];
  assign w_adv[0] = ~r_vld_pipe[0] | w_adv[1];
  assign o_ready  = w_adv[0] & ~i_rst;
  assign o_valid  = r_vld_pipe[2];

  assign w_a         = i_data_a[MSB -: 16];
  assign w_b         = {i_data_b[MSB] ^ i_op, i_data_b[MSB-1 -: 15]};
  assign w_unused_lo = ^{i_data_a[MSB-16:0], i_data_b[MSB-16:0]};

  // ---------------- S1 ----------------
  logic                w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_swap;
  logic [14:0]         w_mag_a, w_mag_b;
  logic [BF_SIG_W-1:0] w_sig_x, w_sig_y;
  logic [BF_EXP_W-1:0] w_exp_y, w_d;
  logic [3:0]          w_sh;
  logic [19:0]         w_ext20;

  always_comb begin
    w_a_zero = (w_a[14:7] == '0);
    w_b_zero = (w_b[14:7] == '0);
    w_a_inf  = (w_a[14:7] == 8'hFF) && (w_a[6:0] == '0);
    w_b_inf  = (w_b[14:7] == 8'hFF) && (w_b[6:0] == '0);
    w_a_nan  = (w_a[14:7] == 8'hFF) && (w_a[6:0] != '0);
    w_b_nan  = (w_b[14:7] == 8'hFF) && (w_b[6:0] != '0);
    w_mag_a  = w_a_zero ? '0 : w_a[14:0];
    w_mag_b  = w_b_zero ? '0 : w_b[14:0];
    w_swap   = (w_mag_b > w_mag_a);
    w_sig_x  = w_swap ? (w_b_zero ? '0 : {1'b1, w_b[6:0]}) : (w_a_zero ? '0 : {1'b1, w_a[6:0]});
    w_sig_y  = w_swap ? (w_a_zero ? '0 : {1'b1, w_a[6:0]}) : (w_b_zero ? '0 : {1'b1, w_b[6:0]});
    w_exp_y  = w_swap ? w_mag_a[14:7] : w_mag_b[14:7];
    w_s1          = '0;
    w_s1.nan      = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_a[15] ^ w_b[15]));
    w_s1.inf      = w_a_inf | w_b_inf;
    w_s1.inf_sign = w_a_inf ? w_a[15] : w_b[15];
    w_s1.sign_x   = w_swap ? w_b[15] : w_a[15];
    w_s1.sign_y   = w_swap ? w_a[15] : w_b[15];
    w_s1.eff_sub  = w_a[15] ^ w_b[15];
    w_s1.exp_x    = w_swap ? w_mag_b[14:7] : w_mag_a[14:7];
    w_d           = w_s1.exp_x - w_exp_y;
    // beyond ALIGN_SAT the small operand is entirely below the sticky position
    w_sh          = (w_d >= 8'(ALIGN_SAT)) ? 4'(ALIGN_SAT) : w_d[3:0];
    w_ext20       = {w_sig_y, 12'b0} >> w_sh;
    w_s1.ext_x    = {w_sig_x, 3'b000};
    w_s1.ext_y    = {w_ext20[19:10], |w_ext20[9:0]};
  end

  always_ff @(posedge i_clk) begin
    if (w_adv[0]) begin
      r_s1   <= w_s1;
      r_tag1 <= i_tag;
    end
  end

  // ---------------- S2 ----------------
  logic [EXT_W:0] w_sum, w_norm;
  logic [3:0]     w_lz;

  always_comb begin
    w_sum = r_s1.eff_sub ? ({1'b0, r_s1.ext_x} - {1'b0, r_s1.ext_y})
                         : ({1'b0, r_s1.ext_x} + {1'b0, r_s1.ext_y});
    w_lz = 4'd11;
    for (int i = 0; i < EXT_W + 1; i++)
      if (w_sum[i]) w_lz = 4'(EXT_W - i);
    w_norm     = w_sum << w_lz;
    w_s2       = '0;
    w_s2.nan   = r_s1.nan;
    w_s2.inf   = r_s1.inf;
    w_s2.zero  = (w_sum == '0);
    // exact zero is +0 unless both inputs were -0
    w_s2.sign  = r_s1.inf ? r_s1.inf_sign :
                 (w_sum == '0) ? (r_s1.sign_x & r_s1.sign_y) : r_s1.sign_x;
    w_s2.expo  = $signed({2'b00, r_s1.exp_x}) + 10'sd1 - $signed({6'b0, w_lz});
    w_s2.sig   = {w_norm[EXT_W:2], |w_norm[1:0]};
  end

  always_ff @(posedge i_clk) begin
    if (w_adv[1]) begin
      r_s2   <= w_s2;
      r_tag2 <= r_tag1;
    end
  end

  // ---------------- S3 ----------------
  bfp16_round_pack u_round_pack (
    .i_s2   (r_s2),
    .o_bf16 (w_res)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      o_data     <= '0;
      o_tag      <= '0;
    end else begin
      if (w_adv[0]) r_vld_pipe[0] <= i_valid;
      if (w_adv[1]) r_vld_pipe[1] <= r_vld_pipe[0];
      if (w_adv[2]) r_vld_pipe[2] <= r_vld_pipe[1];
      if (w_adv[2] && r_vld_pipe[1]) begin
        o_data <= {w_res, {(SIZE_DATA-16){1'b0}}};
        o_tag  <= r_tag2;
      end
    end
  end

endmodule

// File: tb/tb_bfp16_addsub_pipe.sv
// Scoreboard bench for bfp16_addsub_pipe: directed corner cases, backpressure,
// mid-flight reset and random traffic checked against an exact-arithmetic model.
module tb_bfp16_addsub_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, o_ready, i_op, o_valid, i_ready;
  logic [31:0] i_data_a, i_data_b, o_data;
  logic [3:0]  i_tag, o_tag;

  bfp16_addsub_pipe #(.SIZE_DATA(32), .SIZE_TAG(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_tag(i_tag), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_tag(o_tag));

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] data; logic [3:0] tag; int lat; int acc_cyc; } exp_t;
  exp_t q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   rnd_rdy = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------- reference model: exact real sum, then RNE to BF16 ----------
  function automatic real bf2real(input logic [15:0] v);
    logic [63:0] b;
    if (v[14:7] == 8'h00) b = {v[15], 63'b0};
    else b = {v[15], 11'(int'(v[14:7]) + 896), v[6:0], 45'b0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [15:0] real2bf(input real r);
    logic [63:0] b;
    logic [17:0] keep;
    logic [44:0] rem, half;
    int          e;
    b = $realtobits(r);
    if (b[62:0] == 63'b0) return {b[63], 15'h0};
    keep = b[62:45];
    rem  = b[44:0];
    half = 45'h1 << 44;
    if (rem > half || (rem == half && keep[0])) keep = keep + 18'd1;
    e = int'(keep[17:7]) - 896;
    if (e >= 255) return {b[63], 8'hFF, 7'h0};
    if (e < 1) return {b[63], 15'h0};
    return {b[63], 8'(e), keep[6:0]};
  endfunction

  function automatic logic [15:0] ref_addsub(input logic [15:0] a, input logic [15:0] b,
                                             input logic op);
    logic sb, a_nan, b_nan, a_inf, b_inf;
    sb    = b[15] ^ op;
    a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 0);
    b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 0);
    a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 0);
    b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 0);
    if (a_nan || b_nan) return 16'h7FC0;
    if (a_inf && b_inf) return (a[15] == sb) ? {a[15], 8'hFF, 7'h0} : 16'h7FC0;
    if (a_inf) return {a[15], 8'hFF, 7'h0};
    if (b_inf) return {sb, 8'hFF, 7'h0};
    return real2bf(bf2real(a) + bf2real({sb, b[14:0]}));
  endfunction

  function automatic logic [15:0] rnd_bf(input logic [7:0] near);
    int          r, t;
    logic        s;
    logic [7:0]  e;
    logic [6:0]  m;
    r = int'($urandom_range(0, 99));
    s = 1'($urandom);
    m = 7'($urandom);
    if (r < 4) e = 8'h00;
    else if (r < 7) begin e = 8'hFF; m = 7'h0; end
    else if (r < 9) begin e = 8'hFF; m = m | 7'h1; end
    else if (r < 12) e = 8'($urandom_range(252, 254));
    else if (r < 16) e = 8'($urandom_range(1, 3));
    else if (r < 70) begin
      t = int'(near) + int'($urandom_range(0, 6)) - 3;
      if (t < 1) t = 1;
      if (t > 254) t = 254;
      e = 8'(t);
    end else e = 8'($urandom_range(1, 254));
    return {s, e, m};
  endfunction

  // ---------- monitor ----------
  logic        m_held = 1'b0;
  logic [31:0] m_hd;
  logic [3:0]  m_ht;
  exp_t        m_e;

  initial begin
    forever begin
      @(negedge i_clk);
      #4;
      if (m_held) begin
        chk("stall_valid", 64'(o_valid), 64'd1);
        chk("stall_data", 64'(o_data), 64'(m_hd));
        chk("stall_tag", 64'(o_tag), 64'(m_ht));
      end
      m_held = o_valid && !i_ready && !i_rst;
      m_hd   = o_data;
      m_ht   = o_tag;
      if (o_valid && i_ready && !i_rst) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_result: got data %0h tag %0d, expected no result", o_data, o_tag);
        end else begin
          m_e = q.pop_front();
          chk("data", 64'(o_data), 64'(m_e.data));
          chk("tag", 64'(o_tag), 64'(m_e.tag));
          if (m_e.lat > 0) chk("latency", 64'(cyc - m_e.acc_cyc), 64'(m_e.lat));
        end
      end
    end
  end

  // ---------- stimulus ----------
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                      input logic [3:0] tag, input logic [15:0] want, input int lat);
    int   w;
    logic acc;
    w = 0; acc = 1'b0;
    i_valid = 1'b1; i_op = op; i_tag = tag;
    i_data_a = {a, 16'($urandom)};
    i_data_b = {b, 16'($urandom)};
    while (!acc) begin
      if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
      #3;
      acc = o_ready;
      if (acc) q.push_back('{data: {want, 16'h0}, tag: tag, lat: lat, acc_cyc: cyc});
      @(negedge i_clk);
      w++;
      if (!acc && w > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got no o_ready in %0d cycles, expected acceptance", w);
        acc = 1'b1;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    i_ready = 1'b1;
    while (q.size() != 0 && w < 100) begin @(negedge i_clk); w++; end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge i_clk);
  endtask

  typedef struct { logic [15:0] a; logic [15:0] b; logic op; logic [15:0] want; } vec_t;
  vec_t dir[$];
  logic [15:0] bp_a[6], bp_b[6];
  logic        bp_op[6];

  initial begin
    int k, drop_k, drop_c;
    logic [15:0] ra, rb;
    logic        rop;
    i_rst = 1'b1; i_valid = 1'b0; i_op = 1'b0; i_ready = 1'b1;
    i_data_a = '0; i_data_b = '0; i_tag = '0;
    repeat (3) @(negedge i_clk);
    #3;
    chk("rst_o_ready", 64'(o_ready), 64'd0);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_data", 64'(o_data), 64'd0);
    chk("rst_o_tag", 64'(o_tag), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #3;
    chk("post_rst_o_ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);

    // directed corner cases, back-to-back, 3-cycle latency each
    dir = '{'{16'h3F80, 16'h3F80, 1'b0, 16'h4000}, '{16'h3F80, 16'h3F80, 1'b1, 16'h0000},
            '{16'h3F80, 16'h3B80, 1'b0, 16'h3F80}, '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80},
            '{16'h7F80, 16'hFF80, 1'b0, 16'h7FC0}, '{16'hFF80, 16'h4000, 1'b0, 16'hFF80},
            '{16'h0001, 16'h3F80, 1'b0, 16'h3F80}, '{16'h8000, 16'h8000, 1'b0, 16'h8000},
            '{16'h8000, 16'h0000, 1'b1, 16'h8000}, '{16'h3F80, 16'hBF80, 1'b1, 16'h4000},
            '{16'h0100, 16'h00FF, 1'b1, 16'h0000}, '{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0},
            '{16'h3FFF, 16'h3B80, 1'b0, 16'h4000}, '{16'hC000, 16'hFF81, 1'b1, 16'h7FC0}};
    foreach (dir[i]) send(dir[i].a, dir[i].b, dir[i].op, 4'(i), dir[i].want, 3);
    drain();

    // backpressure: 6 back-to-back ops, downstream stalled for cycles 2..7
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = rnd_bf(8'd127); bp_b[i] = rnd_bf(8'd127); bp_op[i] = 1'($urandom);
    end
    k = 0; drop_k = -1; drop_c = -1;
    for (int c = 0; c < 40; c++) begin
      i_ready = !(c >= 2 && c <= 7);
      if (k < 6) begin
        i_valid = 1'b1; i_op = bp_op[k]; i_tag = 4'(k);
        i_data_a = {bp_a[k], 16'($urandom)};
        i_data_b = {bp_b[k], 16'($urandom)};
      end else i_valid = 1'b0;
      #3;
      if (k < 6) begin
        if (o_ready) begin
          q.push_back('{data: {ref_addsub(bp_a[k], bp_b[k], bp_op[k]), 16'h0},
                        tag: 4'(k), lat: 0, acc_cyc: cyc});
          k++;
        end else if (drop_k < 0) begin
          drop_k = k; drop_c = c;
        end
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    chk("bp_accepted", 64'(k), 64'd6);
    chk("bp_drop_after", 64'(drop_k), 64'd3);
    chk("bp_drop_cycle", 64'(drop_c), 64'd3);
    drain();

    // reset with two operations in flight
    send(16'h3F80, 16'h4000, 1'b0, 4'd9, 16'h4040, 0);
    send(16'h4040, 16'h3F80, 1'b1, 4'd10, 16'h4000, 0);
    i_rst = 1'b1;
    q.delete();
    #3;
    chk("midrst_o_ready", 64'(o_ready), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #3;
    chk("midrst_o_valid", 64'(o_valid), 64'd0);
    chk("midrst_o_data", 64'(o_data), 64'd0);
    chk("midrst_o_tag", 64'(o_tag), 64'd0);
    repeat (6) @(negedge i_clk);
    send(16'h4000, 16'h3F80, 1'b1, 4'd7, 16'h3F80, 3);
    drain();

    // random traffic with random downstream stalls
    rnd_rdy = 1;
    for (int n = 0; n < 1500; n++) begin
      ra  = rnd_bf(8'($urandom_range(1, 254)));
      rb  = rnd_bf((ra[14:7] == 8'h00 || ra[14:7] == 8'hFF) ? 8'd127 : ra[14:7]);
      rop = 1'($urandom);
      send(ra, rb, rop, 4'($urandom), ref_addsub(ra, rb, rop), 0);
      if ($urandom_range(0, 4) == 0) begin
        i_ready = ($urandom_range(0, 3) != 0);
        @(negedge i_clk);
      end
    end
    rnd_rdy = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
